// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch and decode stages: instruction geometry
// and the fetch FSM state encoding.
package inst_fetch_pkg;

  localparam int INST_LEN = 17;
  localparam int ADDR_LEN = 5;
  localparam int MEM_SIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_mem.sv
// Instruction memory: synchronous write, asynchronous read, never reset so
// the program survives a fetch-engine reset.
module inst_mem
  import inst_fetch_pkg::*;
#(
  parameter int INST_LEN = inst_fetch_pkg::INST_LEN,
  parameter int ADDR_LEN = inst_fetch_pkg::ADDR_LEN,
  parameter int MEM_SIZE = inst_fetch_pkg::MEM_SIZE
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic [INST_LEN-1:0] wdata,
  input  logic [ADDR_LEN-1:0] raddr,
  output logic [INST_LEN-1:0] rdata
);

  logic [INST_LEN-1:0] mem [MEM_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch engine: walks the instruction memory from address 0 up
// to a latched last address, handing words to decode under a stall handshake.
//
// state   | meaning
// IDLE    | memory programmable, waiting for start
// RUN     | issuing one instruction per unstalled cycle
// DONE    | last instruction issued, draining it to decode
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int INST_LEN = inst_fetch_pkg::INST_LEN,
  parameter int ADDR_LEN = inst_fetch_pkg::ADDR_LEN,
  parameter int MEM_SIZE = inst_fetch_pkg::MEM_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                prog_we,
  input  logic [ADDR_LEN-1:0] prog_addr,
  input  logic [INST_LEN-1:0] prog_data,
  input  logic [ADDR_LEN-1:0] last_pc,
  input  logic                stall,
  output logic [INST_LEN-1:0] inst,
  output logic                inst_valid,
  output logic [ADDR_LEN-1:0] pc,
  output logic                busy,
  output logic                done
);

  fetch_state_t        state;
  logic [ADDR_LEN-1:0] last_pc_q;
  logic [ADDR_LEN-1:0] pc_next;
  logic [INST_LEN-1:0] mem_rdata;
  logic                mem_we;
  logic                issue;

  assign mem_we  = !rst && (state == ST_IDLE) && prog_we;
  assign issue   = (state == ST_RUN) && !(stall && inst_valid);
  assign pc_next = (pc == ADDR_LEN'(MEM_SIZE - 1)) ? '0 : pc + 1'b1;

  inst_mem #(
    .INST_LEN(INST_LEN),
    .ADDR_LEN(ADDR_LEN),
    .MEM_SIZE(MEM_SIZE)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      last_pc_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // a program write wins over a coincident start
          if (start && !prog_we) begin
            state      <= ST_RUN;
            pc         <= '0;
            inst_valid <= 1'b0;
            last_pc_q  <= last_pc;
          end
        end
        ST_RUN: begin
          if (issue) begin
            inst       <= mem_rdata;
            inst_valid <= 1'b1;
            pc         <= pc_next;
            if (pc == last_pc_q) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (start) begin
            state      <= ST_RUN;
            pc         <= '0;
            inst_valid <= 1'b0;
            last_pc_q  <= last_pc;
          end else if (!stall) begin
            inst_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a vector table for the short scenarios plus
// hand sequences for full-memory wrap and reset mid-run.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic                clk = 1'b0;
  logic                rst, start, prog_we, stall;
  logic [ADDR_LEN-1:0] prog_addr, last_pc;
  logic [INST_LEN-1:0] prog_data;
  logic [INST_LEN-1:0] inst;
  logic                inst_valid, busy, done;
  logic [ADDR_LEN-1:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .last_pc(last_pc),
    .stall(stall), .inst(inst), .inst_valid(inst_valid), .pc(pc),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic                rst, start, we;
    logic [ADDR_LEN-1:0] addr;
    logic [INST_LEN-1:0] data;
    logic [ADDR_LEN-1:0] lp;
    logic                stall;
    logic [INST_LEN-1:0] e_inst;
    logic                e_valid;
    logic [ADDR_LEN-1:0] e_pc;
    logic                e_busy, e_done;
  } vec_t;

  vec_t vecs[$];
  logic [INST_LEN-1:0] model [MEM_SIZE];

  function automatic void add(input logic r, s, w, input int a, input int d,
                              input int lp, input logic st, input int ei,
                              input logic ev, input int ep, input logic eb, ed);
    vec_t v;
    v.rst = r; v.start = s; v.we = w; v.addr = ADDR_LEN'(a); v.data = INST_LEN'(d);
    v.lp = ADDR_LEN'(lp); v.stall = st; v.e_inst = INST_LEN'(ei); v.e_valid = ev;
    v.e_pc = ADDR_LEN'(ep); v.e_busy = eb; v.e_done = ed;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [INST_LEN-1:0] ei, input logic ev,
                         input logic [ADDR_LEN-1:0] ep, input logic eb, ed);
    chk({tag, ".inst"}, 32'(inst), 32'(ei));
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(ev));
    chk({tag, ".pc"}, 32'(pc), 32'(ep));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic drive(input logic r, s, w, input logic [ADDR_LEN-1:0] a,
                       input logic [INST_LEN-1:0] d, input logic [ADDR_LEN-1:0] lp,
                       input logic st);
    rst = r; start = s; prog_we = w; prog_addr = a; prog_data = d; last_pc = lp; stall = st;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);

    //   rst s  we addr data     lp st  inst     v  pc b  d
    add(1, 0, 0, 0, 'h00000, 0, 0, 'h00000, 0, 0, 0, 0);
    add(0, 0, 1, 0, 'h00001, 0, 0, 'h00000, 0, 0, 0, 0);
    add(0, 0, 1, 1, 'h08422, 0, 0, 'h00000, 0, 0, 0, 0);
    add(0, 0, 1, 2, 'h1FFFF, 0, 0, 'h00000, 0, 0, 0, 0);
    add(0, 0, 1, 3, 'h00333, 0, 0, 'h00000, 0, 0, 0, 0);
    add(0, 1, 0, 0, 'h00000, 2, 0, 'h00000, 0, 0, 1, 0);
    add(0, 0, 0, 0, 'h00000, 2, 0, 'h00001, 1, 1, 1, 0);
    add(0, 0, 0, 0, 'h00000, 2, 0, 'h08422, 1, 2, 1, 0);
    add(0, 0, 0, 0, 'h00000, 2, 0, 'h1FFFF, 1, 3, 0, 1);
    add(0, 0, 0, 0, 'h00000, 2, 0, 'h1FFFF, 0, 3, 0, 1);
    // rerun with a 3-cycle stall on the second word
    add(0, 1, 0, 0, 'h00000, 2, 0, 'h1FFFF, 0, 0, 1, 0);
    add(0, 0, 0, 0, 'h00000, 2, 1, 'h00001, 1, 1, 1, 0);
    add(0, 0, 0, 0, 'h00000, 2, 0, 'h08422, 1, 2, 1, 0);
    add(0, 0, 0, 0, 'h00000, 2, 1, 'h08422, 1, 2, 1, 0);
    add(0, 0, 0, 0, 'h00000, 2, 1, 'h08422, 1, 2, 1, 0);
    add(0, 0, 0, 0, 'h00000, 2, 1, 'h08422, 1, 2, 1, 0);
    add(0, 0, 0, 0, 'h00000, 2, 0, 'h1FFFF, 1, 3, 0, 1);
    add(0, 0, 0, 0, 'h00000, 2, 1, 'h1FFFF, 1, 3, 0, 1);
    add(0, 0, 0, 0, 'h00000, 2, 0, 'h1FFFF, 0, 3, 0, 1);
    // writes during RUN ignored; last_pc changes mid-run ignored
    add(0, 1, 0, 0, 'h00000, 3, 0, 'h1FFFF, 0, 0, 1, 0);
    add(0, 0, 1, 3, 'h15555, 1, 0, 'h00001, 1, 1, 1, 0);
    add(0, 0, 1, 3, 'h15555, 1, 0, 'h08422, 1, 2, 1, 0);
    add(0, 0, 0, 0, 'h00000, 1, 0, 'h1FFFF, 1, 3, 1, 0);
    add(0, 0, 0, 0, 'h00000, 1, 0, 'h00333, 1, 4, 0, 1);
    add(0, 0, 0, 0, 'h00000, 1, 0, 'h00333, 0, 4, 0, 1);
    // reset beats start; start with prog_we writes and stays IDLE
    add(1, 1, 0, 0, 'h00000, 4, 0, 'h00000, 0, 0, 0, 0);
    add(0, 1, 1, 4, 'h0ABCD, 4, 0, 'h00000, 0, 0, 0, 0);
    add(0, 1, 0, 0, 'h00000, 4, 0, 'h00000, 0, 0, 1, 0);
    add(0, 0, 0, 0, 'h00000, 4, 0, 'h00001, 1, 1, 1, 0);
    add(0, 0, 0, 0, 'h00000, 4, 0, 'h08422, 1, 2, 1, 0);
    add(0, 0, 0, 0, 'h00000, 4, 0, 'h1FFFF, 1, 3, 1, 0);
    add(0, 0, 0, 0, 'h00000, 4, 0, 'h00333, 1, 4, 1, 0);
    add(0, 0, 0, 0, 'h00000, 4, 0, 'h0ABCD, 1, 5, 0, 1);
    add(0, 0, 0, 0, 'h00000, 4, 0, 'h0ABCD, 0, 5, 0, 1);
    // last_pc=0: single issue, stall holds the word in DONE
    add(0, 1, 0, 0, 'h00000, 0, 0, 'h0ABCD, 0, 0, 1, 0);
    add(0, 0, 0, 0, 'h00000, 0, 1, 'h00001, 1, 1, 0, 1);
    add(0, 0, 0, 0, 'h00000, 0, 1, 'h00001, 1, 1, 0, 1);
    add(0, 0, 0, 0, 'h00000, 0, 1, 'h00001, 1, 1, 0, 1);
    add(0, 0, 0, 0, 'h00000, 0, 0, 'h00001, 0, 1, 0, 1);
    add(0, 0, 0, 0, 'h00000, 0, 0, 'h00001, 0, 1, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].we, vecs[i].addr, vecs[i].data,
            vecs[i].lp, vecs[i].stall);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_inst, vecs[i].e_valid,
              vecs[i].e_pc, vecs[i].e_busy, vecs[i].e_done);
    end

    // full memory, last_pc=31: pc wraps to 0
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < MEM_SIZE; i++) begin
      model[i] = INST_LEN'(i * 1031 + 7);
      drive(0, 0, 1, ADDR_LEN'(i), model[i], 0, 0);
      tick();
    end
    drive(0, 1, 0, 0, 0, 31, 0);
    tick();
    chk_all("wrap.start", '0, 1'b0, '0, 1'b1, 1'b0);
    drive(0, 0, 0, 0, 0, 31, 0);
    for (int i = 0; i < MEM_SIZE; i++) begin
      tick();
      chk_all($sformatf("wrap%0d", i), model[i], 1'b1, ADDR_LEN'((i + 1) % MEM_SIZE),
              i != MEM_SIZE - 1, i == MEM_SIZE - 1);
    end
    tick();
    chk_all("wrap.drain", model[MEM_SIZE-1], 1'b0, '0, 1'b0, 1'b1);

    // reset mid-run at pc=5, then rerun from retained memory
    drive(0, 1, 0, 0, 0, 31, 0);
    tick();
    drive(0, 0, 0, 0, 0, 31, 0);
    for (int i = 0; i < 5; i++) tick();
    chk_all("midrun", model[4], 1'b1, ADDR_LEN'(5), 1'b1, 1'b0);
    drive(1, 1, 1, 0, 'h1AAAA, 31, 1);
    tick();
    chk_all("midrun.rst", '0, 1'b0, '0, 1'b0, 1'b0);
    drive(0, 1, 0, 0, 0, 31, 0);
    tick();
    drive(0, 0, 0, 0, 0, 31, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all($sformatf("rerun%0d", i), model[i], 1'b1, ADDR_LEN'(i + 1), 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
